// File: rtl/keypad_operand_ctrl.sv
// keypad_operand_ctrl
// 4x4 matrix keypad front end for the Booth multiplier. It scans the columns,
// synchronises and debounces the rows, and decodes single key presses. It
// builds two signed decimal operands and hands them off over valid/ready.
`timescale 1ns/1ps

module keypad_operand_ctrl #(
    parameter int SCAN_CYCLES    = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int N_DIGITS       = 2,
    parameter int OP_W           = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      row_in,
    output logic [3:0]      col_out,
    output logic            key_valid,
    output logic [3:0]      key_code,
    output logic [OP_W-1:0] op_a,
    output logic [OP_W-1:0] op_b,
    output logic            entry_sel,
    output logic            ops_valid,
    input  logic            ops_ready
);

    localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam int CNT_W  = $clog2(N_DIGITS + 1);

    localparam logic [3:0] KEY_C    = 4'd11;
    localparam logic [3:0] KEY_STAR = 4'd12;
    localparam logic [3:0] KEY_HASH = 4'd14;
    localparam logic [3:0] KEY_D    = 4'd15;

    typedef enum logic [1:0] {ENTER_A, ENTER_B, WAIT_ACK} state_t;

    // Map a key code to {is_digit, decimal value}.
    function automatic logic [4:0] digit_of(input logic [3:0] code);
        case (code)
            4'd0:    digit_of = {1'b1, 4'd1};
            4'd1:    digit_of = {1'b1, 4'd2};
            4'd2:    digit_of = {1'b1, 4'd3};
            4'd4:    digit_of = {1'b1, 4'd4};
            4'd5:    digit_of = {1'b1, 4'd5};
            4'd6:    digit_of = {1'b1, 4'd6};
            4'd8:    digit_of = {1'b1, 4'd7};
            4'd9:    digit_of = {1'b1, 4'd8};
            4'd10:   digit_of = {1'b1, 4'd9};
            4'd13:   digit_of = {1'b1, 4'd0};
            default: digit_of = 5'd0;
        endcase
    endfunction

    logic [3:0]       row_s1_q, row_s2_q;
    logic [SCAN_W-1:0] scan_cnt_q;
    logic [1:0]       col_idx_q;
    logic [1:0]       smp_vld_q;
    logic [1:0]       smp_col0_q, smp_col1_q;
    logic [1:0]       hits_q, hits_next;
    logic [3:0]       hit_code_q, code_next;
    logic [4:0]       cand_q, stable_q, frame_res;   // {key present, code}
    logic [DEB_W-1:0] match_q, match_next;
    logic             key_valid_q;
    logic [3:0]       key_code_q;
    logic             step_last, frame_done, accept;

    state_t           state_q, state_d;
    logic [OP_W-1:0]  mag_a_q, mag_a_d, mag_b_q, mag_b_d, mag_e;
    logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d, neg_e;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d, cnt_e;
    logic [4:0]       dig;

    assign step_last = (scan_cnt_q == SCAN_W'(SCAN_CYCLES - 1));

    // Two-flop synchroniser on the asynchronous row inputs.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1_q <= '0;
            row_s2_q <= '0;
        end else begin
            row_s1_q <= row_in;
            row_s2_q <= row_s1_q;
        end
    end

    // Free-running column scan; the sample strobe is delayed two clocks so it
    // lines up with the synchroniser and tags rows with the column that produced them.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
            col_idx_q  <= '0;
            smp_vld_q  <= '0;
            smp_col0_q <= '0;
            smp_col1_q <= '0;
        end else begin
            if (step_last) begin
                scan_cnt_q <= '0;
                col_idx_q  <= col_idx_q + 2'd1;
            end else begin
                scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
            end
            smp_vld_q  <= {smp_vld_q[0], step_last};
            smp_col0_q <= col_idx_q;
            smp_col1_q <= smp_col0_q;
        end
    end

    assign col_out = 4'b0001 << col_idx_q;

    // Accumulate active rows across the frame; exactly one hit yields a key.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        logic [2:0] pop;
        logic [2:0] sum;
        logic [1:0] row_idx;
        pop     = {2'b0, row_s2_q[0]} + {2'b0, row_s2_q[1]}
                + {2'b0, row_s2_q[2]} + {2'b0, row_s2_q[3]};
        sum     = {1'b0, hits_q} + pop;
        row_idx = 2'd0;
        case (row_s2_q)
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
        hits_next  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        code_next  = (pop == 3'd1) ? {row_idx, smp_col1_q} : hit_code_q;
        frame_done = smp_vld_q[1] && (smp_col1_q == 2'd3);
        frame_res  = (hits_next == 2'd1) ? {1'b1, code_next} : 5'd0;
    end

    // Frame accumulator register, cleared at the end of each frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q     <= '0;
            hit_code_q <= '0;
        end else if (smp_vld_q[1]) begin
            hits_q     <= frame_done ? 2'd0 : hits_next;
            hit_code_q <= frame_done ? 4'd0 : code_next;
        end
    end

    // Count consecutive identical frame results; accept once the run is long enough.
    always_comb begin
        if (frame_res != cand_q) begin
            match_next = DEB_W'(1);
        end else if (match_q == DEB_W'(DEBOUNCE_SCANS)) begin
            match_next = match_q;
        end else begin
            match_next = match_q + DEB_W'(1);
        end
        accept = (match_next >= DEB_W'(DEBOUNCE_SCANS)) && (frame_res != stable_q);
    end

    // Debounced stable state; only a NONE-to-key change produces an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q      <= '0;
            match_q     <= '0;
            stable_q    <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            key_valid_q <= 1'b0;
            if (frame_done) begin
                cand_q  <= frame_res;
                match_q <= match_next;
                if (accept) begin
                    stable_q <= frame_res;
                    if (!stable_q[4] && frame_res[4]) begin
                        key_valid_q <= 1'b1;
                        key_code_q  <= frame_res[3:0];
                    end
                end
            end
        end
    end

    // Entry FSM and operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ENTER_A;
            mag_a_q <= '0;
            neg_a_q <= 1'b0;
            cnt_a_q <= '0;
            mag_b_q <= '0;
            neg_b_q <= 1'b0;
            cnt_b_q <= '0;
        end else begin
            state_q <= state_d;
            mag_a_q <= mag_a_d;
            neg_a_q <= neg_a_d;
            cnt_a_q <= cnt_a_d;
            mag_b_q <= mag_b_d;
            neg_b_q <= neg_b_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    // Key interpretation: edit the operand selected by the state, then apply clear/handshake.
    always_comb begin
        state_d = state_q;
        mag_a_d = mag_a_q;
        neg_a_d = neg_a_q;
        cnt_a_d = cnt_a_q;
        mag_b_d = mag_b_q;
        neg_b_d = neg_b_q;
        cnt_b_d = cnt_b_q;
        mag_e   = (state_q == ENTER_B) ? mag_b_q : mag_a_q;
        neg_e   = (state_q == ENTER_B) ? neg_b_q : neg_a_q;
        cnt_e   = (state_q == ENTER_B) ? cnt_b_q : cnt_a_q;
        dig     = digit_of(key_code_q);

        if (key_valid_q && (state_q != WAIT_ACK) && (key_code_q != KEY_C)) begin
            if (dig[4]) begin
                if (cnt_e < CNT_W'(N_DIGITS)) begin
                    mag_e = (mag_e << 3) + (mag_e << 1) + OP_W'(dig[3:0]);
                    cnt_e = cnt_e + CNT_W'(1);
                end
            end else begin
                case (key_code_q)
                    KEY_STAR: neg_e = ~neg_e;
                    KEY_D: begin
                        mag_e = '0;
                        neg_e = 1'b0;
                        cnt_e = '0;
                    end
                    KEY_HASH: state_d = (state_q == ENTER_A) ? ENTER_B : WAIT_ACK;
                    default: ;
                endcase
            end
            if (state_q == ENTER_A) begin
                mag_a_d = mag_e;
                neg_a_d = neg_e;
                cnt_a_d = cnt_e;
            end else begin
                mag_b_d = mag_e;
                neg_b_d = neg_e;
                cnt_b_d = cnt_e;
            end
        end

        // Both a completed transfer and 'C' drop everything and restart at A.
        if (((state_q == WAIT_ACK) && ops_ready) || (key_valid_q && (key_code_q == KEY_C))) begin
            state_d = ENTER_A;
            mag_a_d = '0;
            neg_a_d = 1'b0;
            cnt_a_d = '0;
            mag_b_d = '0;
            neg_b_d = 1'b0;
            cnt_b_d = '0;
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign op_a      = neg_a_q ? (OP_W'(0) - mag_a_q) : mag_a_q;
    assign op_b      = neg_b_q ? (OP_W'(0) - mag_b_q) : mag_b_q;
    assign entry_sel = (state_q == ENTER_B);
    assign ops_valid = (state_q == WAIT_ACK);

endmodule

// File: tb/tb_keypad_operand_ctrl.sv
// Testbench for keypad_operand_ctrl: a keypad model drives rows from the
// column strobe, a vector table walks key entry, and hand sequences cover
// handshake, abort and reset-while-held.
`timescale 1ns/1ps

module tb_keypad_operand_ctrl;

    localparam int FRAME = 8;   // 4 columns x SCAN_CYCLES(2)

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] op_a, op_b;
    logic       entry_sel, ops_valid;
    logic       ops_ready = 1'b0;

    logic [15:0] pressed = 16'h0;
    int n_checks = 0;
    int n_errors = 0;
    int kv_count = 0;
    int ov_cycles = 0;

    keypad_operand_ctrl #(
        .SCAN_CYCLES(2), .DEBOUNCE_SCANS(2), .N_DIGITS(2), .OP_W(8)
    ) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
        .key_valid(key_valid), .key_code(key_code), .op_a(op_a), .op_b(op_b),
        .entry_sel(entry_sel), .ops_valid(ops_valid), .ops_ready(ops_ready)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key connects its column drive to its row.
    always_comb begin
        row_in = 4'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && col_out[c]) row_in[r] = 1'b1;
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) kv_count++;
        if (ops_valid === 1'b1) ov_cycles++;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [15:0] mask;
        int          frames;
        int          kv;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sel;
        logic        ov;
        logic [3:0]  kc;
    } vec_t;

    vec_t tab_a[21];
    vec_t tab_b[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [15:0] mask, input int frames);
        @(negedge clk);
        pressed = mask;
        repeat (frames * FRAME) @(negedge clk);
        pressed = 16'h0;
        repeat (3 * FRAME) @(negedge clk);
    endtask

    task automatic run_vec(input string tag, input int i, input vec_t v);
        int base;
        base = kv_count;
        press(v.mask, v.frames);
        check($sformatf("%s%0d_pulses", tag, i), kv_count - base, v.kv);
        check($sformatf("%s%0d_key_code", tag, i), {28'h0, key_code}, {28'h0, v.kc});
        check($sformatf("%s%0d_op_a", tag, i), {24'h0, op_a}, {24'h0, v.a});
        check($sformatf("%s%0d_op_b", tag, i), {24'h0, op_b}, {24'h0, v.b});
        check($sformatf("%s%0d_entry_sel", tag, i), {31'h0, entry_sel}, {31'h0, v.sel});
        check($sformatf("%s%0d_ops_valid", tag, i), {31'h0, ops_valid}, {31'h0, v.ov});
    endtask

    initial begin
        int base;
        //            mask      frm kv  op_a    op_b   sel   ov    code
        tab_a[0]  = '{16'h0020, 13, 1, 8'd5,   8'd0, 1'b0, 1'b0, 4'd5 };  // "5" held: one pulse
        tab_a[1]  = '{16'h8000, 3,  1, 8'd0,   8'd0, 1'b0, 1'b0, 4'd15};  // D clears
        tab_a[2]  = '{16'h0100, 1,  0, 8'd0,   8'd0, 1'b0, 1'b0, 4'd15};  // 1-frame glitch
        tab_a[3]  = '{16'h0060, 3,  0, 8'd0,   8'd0, 1'b0, 1'b0, 4'd15};  // 5+6 together
        tab_a[4]  = '{16'h0001, 3,  1, 8'd1,   8'd0, 1'b0, 1'b0, 4'd0 };  // 1
        tab_a[5]  = '{16'h0002, 3,  1, 8'd12,  8'd0, 1'b0, 1'b0, 4'd1 };  // 2
        tab_a[6]  = '{16'h0004, 3,  1, 8'd12,  8'd0, 1'b0, 1'b0, 4'd2 };  // 3 over limit
        tab_a[7]  = '{16'h1000, 3,  1, 8'hF4,  8'd0, 1'b0, 1'b0, 4'd12};  // *
        tab_a[8]  = '{16'h8000, 3,  1, 8'd0,   8'd0, 1'b0, 1'b0, 4'd15};  // D
        tab_a[9]  = '{16'h0100, 3,  1, 8'd7,   8'd0, 1'b0, 1'b0, 4'd8 };  // 7
        tab_a[10] = '{16'h4000, 3,  1, 8'd7,   8'd0, 1'b1, 1'b0, 4'd14};  // # -> B
        tab_a[11] = '{16'h0008, 3,  1, 8'd7,   8'd0, 1'b1, 1'b0, 4'd3 };  // A ignored
        tab_a[12] = '{16'h0400, 3,  1, 8'd7,   8'd9, 1'b1, 1'b0, 4'd10};  // 9 into B
        tab_a[13] = '{16'h0800, 3,  1, 8'd0,   8'd0, 1'b0, 1'b0, 4'd11};  // C clears all
        tab_a[14] = '{16'h0001, 3,  1, 8'd1,   8'd0, 1'b0, 1'b0, 4'd0 };  // 1
        tab_a[15] = '{16'h0002, 3,  1, 8'd12,  8'd0, 1'b0, 1'b0, 4'd1 };  // 2
        tab_a[16] = '{16'h1000, 3,  1, 8'hF4,  8'd0, 1'b0, 1'b0, 4'd12};  // * -> -12
        tab_a[17] = '{16'h4000, 3,  1, 8'hF4,  8'd0, 1'b1, 1'b0, 4'd14};  // # -> B
        tab_a[18] = '{16'h0400, 3,  1, 8'hF4,  8'd9, 1'b1, 1'b0, 4'd10};  // 9
        tab_a[19] = '{16'h4000, 3,  1, 8'hF4,  8'd9, 1'b0, 1'b1, 4'd14};  // # -> WAIT_ACK
        tab_a[20] = '{16'h0010, 3,  1, 8'hF4,  8'd9, 1'b0, 1'b1, 4'd4 };  // 4 ignored
        tab_b[0]  = '{16'h0020, 3,  1, 8'd5,   8'd0, 1'b0, 1'b0, 4'd5 };
        tab_b[1]  = '{16'h4000, 3,  1, 8'd5,   8'd0, 1'b1, 1'b0, 4'd14};
        tab_b[2]  = '{16'h4000, 3,  1, 8'd5,   8'd0, 1'b0, 1'b1, 4'd14};
        tab_b[3]  = '{16'h0800, 3,  1, 8'd0,   8'd0, 1'b0, 1'b0, 4'd11};  // abort
        tab_b[4]  = '{16'h4000, 3,  1, 8'd0,   8'd0, 1'b1, 1'b0, 4'd14};  // back in A
        tab_b[5]  = '{16'h0800, 3,  1, 8'd0,   8'd0, 1'b0, 1'b0, 4'd11};

        // Reset and scan rotation.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_outputs", {11'h0, key_valid, key_code, op_a, op_b, entry_sel, ops_valid}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("scan_col_%0d", i), {28'h0, col_out}, {28'h0, 4'b0001 << ((i / 2) % 4)});
            @(negedge clk);
        end
        check("idle_outputs", {11'h0, key_valid, key_code, op_a, op_b, entry_sel, ops_valid}, 32'h0);

        for (int i = 0; i < 21; i++) run_vec("a", i, tab_a[i]);

        // One-cycle ops_ready pulse completes the transfer.
        check("hs_hold_valid", {31'h0, ops_valid}, 32'h1);
        ops_ready = 1'b1;
        @(negedge clk);
        ops_ready = 1'b0;
        check("hs_valid_drop", {31'h0, ops_valid}, 32'h0);
        check("hs_op_a_clr", {24'h0, op_a}, 32'h0);
        check("hs_op_b_clr", {24'h0, op_b}, 32'h0);
        check("hs_sel_clr", {31'h0, entry_sel}, 32'h0);

        // ops_ready tied high: valid lasts exactly one cycle.
        ops_ready = 1'b1;
        press(16'h4000, 3);
        check("tied_sel_b", {31'h0, entry_sel}, 32'h1);
        base = ov_cycles;
        press(16'h4000, 3);
        check("tied_valid_cycles", ov_cycles - base, 32'd1);
        check("tied_sel_a", {31'h0, entry_sel}, 32'h0);
        ops_ready = 1'b0;

        for (int i = 0; i < 6; i++) run_vec("b", i, tab_b[i]);

        // Reset while a key stays held: a fresh debounce is required.
        @(negedge clk);
        pressed = 16'h0020;
        base = kv_count;
        repeat (4 * FRAME) @(negedge clk);
        check("held_pre_pulse", kv_count - base, 32'd1);
        check("held_pre_op_a", {24'h0, op_a}, 32'd5);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_key_code", {28'h0, key_code}, 32'h0);
        check("rst_op_a", {24'h0, op_a}, 32'h0);
        check("rst_col", {28'h0, col_out}, 32'h1);
        rst = 1'b0;
        base = kv_count;
        repeat (12) @(negedge clk);
        check("held_no_early_pulse", kv_count - base, 32'd0);
        repeat (20) @(negedge clk);
        check("held_fresh_pulse", kv_count - base, 32'd1);
        check("held_key_code", {28'h0, key_code}, 32'd5);
        check("held_op_a", {24'h0, op_a}, 32'd5);
        pressed = 16'h0;
        repeat (3 * FRAME) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
